// File: rtl/logo_mix_pkg.sv
// Shared types and constants for the logo_mix marker path (w_mark_gen / w_detect).
package logo_mix_pkg;
  localparam logic [23:0] PIX_WHITE = 24'hffffff;

  typedef enum logic [1:0] {WAIT_SOP, ACTIVE, UPDATE} fsm_t;
  typedef logic [15:0] coord_t;

  function automatic coord_t clamp_coord(input int v, input int lo, input int hi);
    int r;
    r = v;
    if (r < lo) r = lo;
    if (r > hi) r = hi;
    return coord_t'(r);
  endfunction
endpackage

// File: rtl/w_mark_gen_pos.sv
// Marker position keeper: pending host load, clamping and per-frame bounce motion.
module w_mark_pos
  import logo_mix_pkg::*;
#(
  parameter int SIZE   = 10,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int INIT_X = 10,
  parameter int INIT_Y = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  coord_t     mark_x,
  input  coord_t     mark_y,
  input  logic       mark_load,
  input  logic       auto_move,
  input  logic [3:0] step_x,
  input  logic [3:0] step_y,
  input  logic       upd,
  output coord_t     pos_x,
  output coord_t     pos_y
);
  localparam int XLO = SIZE - 1;
  localparam int XHI = WIDTH - 1;
  localparam int YLO = SIZE - 1;
  localparam int YHI = HEIGHT - 1;
  localparam coord_t INIT_XC = clamp_coord(INIT_X, XLO, XHI);
  localparam coord_t INIT_YC = clamp_coord(INIT_Y, YLO, YHI);

  coord_t pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  coord_t pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic   pend_vld_q, pend_vld_d;
  logic   dir_x_q, dir_x_d, dir_y_q, dir_y_d;  // 1 = moving toward smaller coordinates
  int     nx, ny;

  always_comb begin
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    pend_x_d   = pend_x_q;
    pend_y_d   = pend_y_q;
    pend_vld_d = pend_vld_q;
    dir_x_d    = dir_x_q;
    dir_y_d    = dir_y_q;
    nx = dir_x_q ? int'(pos_x_q) - int'(step_x) : int'(pos_x_q) + int'(step_x);
    ny = dir_y_q ? int'(pos_y_q) - int'(step_y) : int'(pos_y_q) + int'(step_y);
    if (mark_load) begin
      pend_vld_d = 1'b1;
      pend_x_d   = mark_x;
      pend_y_d   = mark_y;
    end
    if (upd) begin
      // A load landing on the update cycle is applied directly and not left pending.
      if (mark_load || pend_vld_q) begin
        pos_x_d    = clamp_coord(int'(mark_load ? mark_x : pend_x_q), XLO, XHI);
        pos_y_d    = clamp_coord(int'(mark_load ? mark_y : pend_y_q), YLO, YHI);
        pend_vld_d = 1'b0;
      end else if (auto_move) begin
        if (step_x != '0) begin
          pos_x_d = clamp_coord(nx, XLO, XHI);
          if ((!dir_x_q && nx >= XHI) || (dir_x_q && nx <= XLO)) dir_x_d = ~dir_x_q;
        end
        if (step_y != '0) begin
          pos_y_d = clamp_coord(ny, YLO, YHI);
          if ((!dir_y_q && ny >= YHI) || (dir_y_q && ny <= YLO)) dir_y_d = ~dir_y_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x_q    <= INIT_XC;
      pos_y_q    <= INIT_YC;
      pend_x_q   <= INIT_XC;
      pend_y_q   <= INIT_YC;
      pend_vld_q <= 1'b0;
      dir_x_q    <= 1'b0;
      dir_y_q    <= 1'b0;
    end else begin
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      pend_vld_q <= pend_vld_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
    end
  end

  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;
endmodule

// File: rtl/w_mark_gen.sv
// Overlays a SIZE x SIZE white marker on a 24-bit video stream through one
// register stage; position is fixed per frame and updated between frames.
module w_mark_gen
  import logo_mix_pkg::*;
#(
  parameter int SIZE   = 10,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int INIT_X = 10,
  parameter int INIT_Y = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] video_in_data,
  input  logic        video_in_valid,
  input  logic        video_in_sop,
  input  logic        video_in_eop,
  output logic        video_in_ready,
  output logic [23:0] video_out_data,
  output logic        video_out_valid,
  output logic        video_out_sop,
  output logic        video_out_eop,
  input  logic        video_out_ready,
  input  logic        mark_en,
  input  logic [15:0] mark_x,
  input  logic [15:0] mark_y,
  input  logic        mark_load,
  input  logic        auto_move,
  input  logic [3:0]  step_x,
  input  logic [3:0]  step_y,
  output logic [15:0] pos_x,
  output logic [15:0] pos_y,
  output logic        frame_done
);
  localparam logic signed [16:0] SZM1 = 17'(SIZE - 1);

  fsm_t        state_q, state_d;
  logic [23:0] data_q, data_d;
  logic        valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  coord_t      cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d, pix_x, pix_y;
  logic        in_xfer, in_frame, in_sq;
  logic signed [16:0] x_hi, x_lo, y_hi, y_lo, px, py;

  w_mark_pos #(.SIZE(SIZE), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .INIT_X(INIT_X), .INIT_Y(INIT_Y)) u_pos (
    .clk(clk), .rst(rst), .mark_x(mark_x), .mark_y(mark_y), .mark_load(mark_load),
    .auto_move(auto_move), .step_x(step_x), .step_y(step_y), .upd(state_q == UPDATE),
    .pos_x(pos_x), .pos_y(pos_y)
  );

  assign video_in_ready = video_out_ready | ~valid_q;
  assign in_xfer  = video_in_valid & video_in_ready;
  assign in_frame = (state_q == ACTIVE) | video_in_sop;
  assign pix_x    = video_in_sop ? '0 : cnt_x_q;
  assign pix_y    = video_in_sop ? '0 : cnt_y_q;

  // Signed 17-bit window so a marker near the origin never wraps its lower edge.
  assign x_hi = $signed({1'b0, pos_x});
  assign y_hi = $signed({1'b0, pos_y});
  assign x_lo = x_hi - SZM1;
  assign y_lo = y_hi - SZM1;
  assign px   = $signed({1'b0, pix_x});
  assign py   = $signed({1'b0, pix_y});
  assign in_sq = mark_en & in_frame & (px >= x_lo) & (px <= x_hi) & (py >= y_lo) & (py <= y_hi);

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    cnt_x_d = cnt_x_q;
    cnt_y_d = cnt_y_q;
    state_d = state_q;
    if (video_out_ready) valid_d = 1'b0;
    if (in_xfer) begin
      valid_d = 1'b1;
      data_d  = in_sq ? PIX_WHITE : video_in_data;
      sop_d   = video_in_sop;
      eop_d   = video_in_eop;
      if (in_frame) begin
        if (pix_x == coord_t'(WIDTH - 1)) begin
          cnt_x_d = '0;
          cnt_y_d = (pix_y == coord_t'(HEIGHT - 1)) ? pix_y : pix_y + 16'd1;
        end else begin
          cnt_x_d = pix_x + 16'd1;
          cnt_y_d = pix_y;
        end
      end
    end
    // A sop arriving during UPDATE starts the next frame rather than being lost.
    case (state_q)
      WAIT_SOP, UPDATE: begin
        if (in_xfer && video_in_sop) state_d = video_in_eop ? UPDATE : ACTIVE;
        else if (state_q == UPDATE)  state_d = WAIT_SOP;
      end
      ACTIVE:  if (in_xfer && video_in_eop) state_d = UPDATE;
      default: state_d = WAIT_SOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_SOP;
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      cnt_x_q <= '0;
      cnt_y_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      cnt_x_q <= cnt_x_d;
      cnt_y_q <= cnt_y_d;
    end
  end

  assign video_out_data  = data_q;
  assign video_out_valid = valid_q;
  assign video_out_sop   = sop_q;
  assign video_out_eop   = eop_q;
  assign frame_done      = valid_q & video_out_ready & eop_q;
endmodule

// File: tb/tb_w_mark_gen.sv
// Directed bench for w_mark_gen on an 8x6 frame with a 2x2 marker.
module tb_w_mark_gen;
  localparam int W = 8, H = 6, SZ = 2, NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] video_in_data, video_out_data;
  logic        video_in_valid, video_in_sop, video_in_eop, video_in_ready;
  logic        video_out_valid, video_out_sop, video_out_eop, video_out_ready;
  logic        mark_en, mark_load, auto_move, frame_done;
  logic [15:0] mark_x, mark_y, pos_x, pos_y;
  logic [3:0]  step_x, step_y;

  always #5 clk = ~clk;

  w_mark_gen #(.SIZE(SZ), .WIDTH(W), .HEIGHT(H), .INIT_X(3), .INIT_Y(2)) dut (
    .clk(clk), .rst(rst),
    .video_in_data(video_in_data), .video_in_valid(video_in_valid),
    .video_in_sop(video_in_sop), .video_in_eop(video_in_eop), .video_in_ready(video_in_ready),
    .video_out_data(video_out_data), .video_out_valid(video_out_valid),
    .video_out_sop(video_out_sop), .video_out_eop(video_out_eop), .video_out_ready(video_out_ready),
    .mark_en(mark_en), .mark_x(mark_x), .mark_y(mark_y), .mark_load(mark_load),
    .auto_move(auto_move), .step_x(step_x), .step_y(step_y),
    .pos_x(pos_x), .pos_y(pos_y), .frame_done(frame_done)
  );

  int checks = 0, errors = 0;
  bit stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Output monitor: a transfer happens at the next posedge when valid&ready at negedge.
  logic [23:0] mq_data[$];
  logic        mq_sop[$], mq_eop[$];
  int          done_cnt;
  always @(negedge clk) begin
    if (!rst && video_out_valid && video_out_ready) begin
      mq_data.push_back(video_out_data);
      mq_sop.push_back(video_out_sop);
      mq_eop.push_back(video_out_eop);
    end
    if (!rst && frame_done) done_cnt++;
  end

  always @(posedge clk) begin
    #1;
    video_out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  typedef struct {
    bit en; bit pat; bit stl; bit amv; bit ld;
    logic [15:0] lx, ly; logic [3:0] sx, sy;
    int ex, ey;
  } frm_t;
  frm_t tbl[8];

  task automatic send_px(input logic [23:0] d, input bit s, input bit e, input bit ld);
    bit rdy;
    int to;
    video_in_valid = 1'b1;
    video_in_data  = d;
    video_in_sop   = s;
    video_in_eop   = e;
    mark_load      = ld;
    to = 0;
    rdy = 1'b0;
    while (!rdy && to < 100) begin
      @(negedge clk);
      rdy = video_in_ready;
      @(posedge clk);
      #1;
      mark_load = 1'b0;
      to++;
    end
    if (!rdy) chk("in_ready_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic send_frame(input frm_t f, input bit first);
    logic [23:0] din[NPIX];
    logic [23:0] expd;
    int to;
    mark_en   = f.en;
    auto_move = f.amv;
    step_x    = f.sx;
    step_y    = f.sy;
    mark_x    = f.lx;
    mark_y    = f.ly;
    stall     = f.stl;
    chk("frame_pos_x", 32'(pos_x), 32'(f.ex));
    chk("frame_pos_y", 32'(pos_y), 32'(f.ey));
    mq_data.delete(); mq_sop.delete(); mq_eop.delete();
    done_cnt = 0;
    for (int i = 0; i < NPIX; i++) begin
      din[i] = f.pat ? 24'h5a3c00 + 24'(i) * 24'h010307 : 24'h000000;
      send_px(din[i], i == 0, i == NPIX - 1, f.ld && i == 10);
      if (first && i == 0) begin
        chk("latency_valid", 32'(video_out_valid), 32'd1);
        chk("latency_sop", 32'(video_out_sop), 32'd1);
        chk("latency_data", 32'(video_out_data), 32'(din[0]));
      end
    end
    video_in_valid = 1'b0;
    video_in_sop   = 1'b0;
    video_in_eop   = 1'b0;
    to = 0;
    while (mq_data.size() < NPIX && to < 300) begin
      @(posedge clk);
      to++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("out_count", 32'(mq_data.size()), 32'(NPIX));
    chk("frame_done_count", 32'(done_cnt), 32'd1);
    if (mq_data.size() == NPIX) begin
      chk("out_sop_first", 32'(mq_sop[0]), 32'd1);
      chk("out_eop_last", 32'(mq_eop[NPIX-1]), 32'd1);
      for (int i = 0; i < NPIX; i++) begin
        int x, y;
        x = i % W;
        y = i / W;
        expd = (f.en && x >= f.ex - SZ + 1 && x <= f.ex && y >= f.ey - SZ + 1 && y <= f.ey)
               ? 24'hffffff : din[i];
        chk($sformatf("pix_%0d_%0d", x, y), 32'(mq_data[i]), 32'(expd));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //        en  pat stl amv ld  lx     ly     sx    sy    ex ey
    tbl[0] = '{1, 0, 0, 0, 0, 16'd0, 16'd0, 4'd0, 4'd0, 3, 2};
    tbl[1] = '{1, 0, 1, 0, 1, 16'd5, 16'd4, 4'd0, 4'd0, 3, 2};
    tbl[2] = '{1, 1, 1, 1, 1, 16'd6, 16'd4, 4'd3, 4'd3, 5, 4};
    tbl[3] = '{1, 0, 0, 1, 0, 16'd0, 16'd0, 4'd3, 4'd3, 6, 4};
    tbl[4] = '{1, 1, 1, 1, 0, 16'd0, 16'd0, 4'd3, 4'd3, 7, 5};
    tbl[5] = '{1, 0, 0, 0, 1, 16'd0, 16'd0, 4'd3, 4'd3, 4, 2};
    tbl[6] = '{1, 1, 0, 0, 0, 16'd0, 16'd0, 4'd0, 4'd0, 1, 1};
    tbl[7] = '{0, 1, 1, 0, 0, 16'd0, 16'd0, 4'd0, 4'd0, 1, 1};

    rst = 1'b1;
    video_in_data = '0; video_in_valid = 1'b0; video_in_sop = 1'b0; video_in_eop = 1'b0;
    video_out_ready = 1'b1;
    mark_en = 1'b1; mark_x = '0; mark_y = '0; mark_load = 1'b0;
    auto_move = 1'b0; step_x = '0; step_y = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(video_out_valid), 32'd0);
    chk("rst_out_data", 32'(video_out_data), 32'd0);
    chk("rst_out_sop_eop", 32'({video_out_sop, video_out_eop}), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_pos_x", 32'(pos_x), 32'd3);
    chk("rst_pos_y", 32'(pos_y), 32'd2);
    chk("rst_in_ready", 32'(video_in_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int k = 0; k < 8; k++) send_frame(tbl[k], k == 0);

    // Reset in the middle of a frame: stream dropped, position back to init.
    stall = 1'b0;
    mark_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send_px(24'h000000, i == 0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    video_in_valid = 1'b0;
    chk("midrst_out_valid", 32'(video_out_valid), 32'd0);
    chk("midrst_pos_x", 32'(pos_x), 32'd3);
    chk("midrst_pos_y", 32'(pos_y), 32'd2);

    // Non-sop pixels before a frame start pass through untouched.
    mq_data.delete(); mq_sop.delete(); mq_eop.delete();
    send_px(24'h00ffee, 1'b0, 1'b0, 1'b0);
    send_px(24'h123456, 1'b0, 1'b0, 1'b0);
    video_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stray_count", 32'(mq_data.size()), 32'd2);
    if (mq_data.size() == 2) begin
      chk("stray_data0", 32'(mq_data[0]), 32'h00ffee);
      chk("stray_data1", 32'(mq_data[1]), 32'h123456);
    end

    send_frame(tbl[0], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
